// File: rtl/seg7_scan_driver_if.sv
// Display-word bundle between the control layer and the 7-segment scan driver.
// The control layer drives the word; the driver returns the panel signals.
interface seg7_scan_driver_if;
    logic [23:0] num_in;
    logic [5:0]  dp_in;
    logic [5:0]  blink_mask;
    logic [7:0]  seg_out;
    logic [5:0]  dig_sel;
    logic        frame_tick;

    modport master (
        output num_in, dp_in, blink_mask,
        input  seg_out, dig_sel, frame_tick
    );

    modport slave (
        input  num_in, dp_in, blink_mask,
        output seg_out, dig_sel, frame_tick
    );
endinterface

// File: rtl/seg7_scan_driver.sv
// 6-digit multiplexed 7-segment driver with frame-snapshotted word,
// glyph decode, per-digit decimal points and blinking.
module seg7_scan_driver #(
    parameter int SCAN_DIV       = 50000,
    parameter int BLINK_FRAMES   = 250,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit DIG_ACTIVE_LOW = 1'b1
) (
    input logic              CLK,
    input logic              RSTn,
    seg7_scan_driver_if.slave bus
);
    localparam int PW = $clog2(SCAN_DIV);
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [PW-1:0] PMAX = PW'(SCAN_DIV - 1);
    localparam logic [FW-1:0] FMAX = FW'(BLINK_FRAMES - 1);
    localparam logic [7:0] SEG_OFF = {8{SEG_ACTIVE_LOW}};
    localparam logic [5:0] DIG_OFF = {6{DIG_ACTIVE_LOW}};

    logic [PW-1:0] pre_q, pre_d;
    logic [2:0]    idx_q, idx_d;
    logic [FW-1:0] fcnt_q, fcnt_d;
    logic          phase_q, phase_d;
    logic [23:0]   num_sh_q, num_sh_d;
    logic [5:0]    dp_sh_q, dp_sh_d;
    logic [5:0]    blink_sh_q, blink_sh_d;
    logic [7:0]    seg_q, seg_d;
    logic [5:0]    dig_q, dig_d;

    logic          wrap;
    logic          frame;
    logic [3:0]    nib;
    logic [6:0]    segs;
    logic [7:0]    glyph;
    logic          blank;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            pre_q      <= '0;
            idx_q      <= '0;
            fcnt_q     <= '0;
            phase_q    <= 1'b0;
            num_sh_q   <= 24'hCCCCCC;
            dp_sh_q    <= '0;
            blink_sh_q <= '0;
            seg_q      <= SEG_OFF;
            dig_q      <= DIG_OFF;
        end else begin
            pre_q      <= pre_d;
            idx_q      <= idx_d;
            fcnt_q     <= fcnt_d;
            phase_q    <= phase_d;
            num_sh_q   <= num_sh_d;
            dp_sh_q    <= dp_sh_d;
            blink_sh_q <= blink_sh_d;
            seg_q      <= seg_d;
            dig_q      <= dig_d;
        end
    end

    always_comb begin
        wrap       = (pre_q == PMAX);
        frame      = wrap && (idx_q == 3'd5);
        pre_d      = wrap ? '0 : pre_q + 1'b1;
        idx_d      = idx_q;
        fcnt_d     = fcnt_q;
        phase_d    = phase_q;
        num_sh_d   = num_sh_q;
        dp_sh_d    = dp_sh_q;
        blink_sh_d = blink_sh_q;

        if (wrap) begin
            idx_d = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
        end

        // Snapshot only at the frame boundary so a frame never tears.
        if (frame) begin
            num_sh_d   = bus.num_in;
            dp_sh_d    = bus.dp_in;
            blink_sh_d = bus.blink_mask;
            if (fcnt_q == FMAX) begin
                fcnt_d  = '0;
                phase_d = ~phase_q;
            end else begin
                fcnt_d = fcnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        nib = num_sh_q[{idx_q, 2'b00} +: 4];
        segs = 7'h00;
        unique case (nib)
            4'h0:    segs = 7'h3F;
            4'h1:    segs = 7'h06;
            4'h2:    segs = 7'h5B;
            4'h3:    segs = 7'h4F;
            4'h4:    segs = 7'h66;
            4'h5:    segs = 7'h6D;
            4'h6:    segs = 7'h7D;
            4'h7:    segs = 7'h07;
            4'h8:    segs = 7'h7F;
            4'h9:    segs = 7'h6F;
            4'hA:    segs = 7'h40;
            4'hB:    segs = 7'h08;
            default: segs = 7'h00;
        endcase
        blank = phase_q & blink_sh_q[idx_q];
        glyph = blank ? 8'h00 : {dp_sh_q[idx_q], segs};
    end

    // Digit enables drop for the first cycle of each slot to avoid ghosting.
    always_comb begin
        seg_d = seg_q;
        dig_d = DIG_OFF;
        if (pre_q != '0) begin
            seg_d = glyph ^ SEG_OFF;
            dig_d = (6'b000001 << idx_q) ^ DIG_OFF;
        end
    end

    assign bus.seg_out    = seg_q;
    assign bus.dig_sel    = dig_q;
    assign bus.frame_tick = frame;
endmodule
